pla_preimage_search: RTL

Sequential inverse-lookup engine for the combinational 5-input/14-output PLA benchmark tables. Given a 14-bit target response and care mask, it sweeps every input code through an external table evaluator, one code per clock, and reports the first matching code, the match count and a hit bitmap. It is the reverse direction of a table evaluator: response → input code(s). The power-aware synthesis bench uses it to build preimage sets and run equivalence sweeps on synthesized netlists.

---
 rtl/pla_preimage_if.sv | 25 ++
 rtl/pla_preimage_search.sv | 95 +++++++++
 2 files changed

// File: rtl/pla_preimage_if.sv
// pla_preimage_if: request/evaluator/response bundle for the PLA preimage search engine
interface pla_preimage_if #(parameter int IN_W = 5, parameter int OUT_W = 14);
  logic                 req_valid;
  logic                 req_ready;
  logic [OUT_W-1:0]     req_target;
  logic [OUT_W-1:0]     req_mask;
  logic                 req_stop_first;
  logic                 abort;
  logic [IN_W-1:0]      cand_o;
  logic [OUT_W-1:0]     resp_i;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_found;
  logic [IN_W-1:0]      rsp_first;
  logic [IN_W:0]        rsp_count;
  logic [(2**IN_W)-1:0] rsp_hitmap;
  modport slave (
    input  req_valid, req_target, req_mask, req_stop_first, abort, resp_i, rsp_ready,
    output req_ready, cand_o, rsp_valid, rsp_found, rsp_first, rsp_count, rsp_hitmap
  );
  modport master (
    output req_valid, req_target, req_mask, req_stop_first, abort, resp_i, rsp_ready,
    input  req_ready, cand_o, rsp_valid, rsp_found, rsp_first, rsp_count, rsp_hitmap
  );
endinterface

// File: rtl/pla_preimage_search.sv
// pla_preimage_search: sweeps every input code through an external evaluator and
// collects first match, match count and hit bitmap for a masked target response.
module pla_preimage_search #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 14
) (
  input logic clk,
  input logic rst_n,
  pla_preimage_if.slave bus
);
  localparam int N = 2**IN_W;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;
  state_t state_q, state_d;
  logic [IN_W-1:0] cand_q, cand_d, first_q, first_d;
  logic [OUT_W-1:0] tgt_q, tgt_d, mask_q, mask_d;
  logic stop_q, stop_d, found_q, found_d, ready_q, ready_d, valid_q, valid_d;
  logic [IN_W:0] count_q, count_d;
  logic [N-1:0] hit_q, hit_d;
  logic match, last;
  // target is stored pre-masked so the compare is a single masked equality
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    first_d = first_q;
    tgt_d   = tgt_q;
    mask_d  = mask_q;
    stop_d  = stop_q;
    found_d = found_q;
    count_d = count_q;
    hit_d   = hit_q;
    match   = (bus.resp_i & mask_q) == tgt_q;
    last    = &cand_q;
    if (state_q == IDLE && bus.req_valid) begin
      tgt_d   = bus.req_target & bus.req_mask;
      mask_d  = bus.req_mask;
      stop_d  = bus.req_stop_first;
      found_d = 1'b0;
      first_d = '0;
      count_d = '0;
      hit_d   = '0;
      cand_d  = '0;
      state_d = SWEEP;
    end else if (state_q == SWEEP && bus.abort) begin
      cand_d  = '0;
      state_d = IDLE;
    end else if (state_q == SWEEP) begin
      if (match) begin
        hit_d[cand_q] = 1'b1;
        count_d = count_q + 1'b1;
        first_d = found_q ? first_q : cand_q;
        found_d = 1'b1;
      end
      state_d = (last || (stop_q && match && !found_q)) ? DONE : SWEEP;
      cand_d  = (state_d == DONE) ? '0 : cand_q + 1'b1;
    end else if (state_q == DONE && bus.rsp_ready) begin
      state_d = IDLE;
    end
    ready_d = state_d == IDLE;
    valid_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      first_q <= '0;
      tgt_q   <= '0;
      mask_q  <= '0;
      stop_q  <= 1'b0;
      found_q <= 1'b0;
      count_q <= '0;
      hit_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      first_q <= first_d;
      tgt_q   <= tgt_d;
      mask_q  <= mask_d;
      stop_q  <= stop_d;
      found_q <= found_d;
      count_q <= count_d;
      hit_q   <= hit_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end
  assign bus.req_ready  = ready_q;
  assign bus.rsp_valid  = valid_q;
  assign bus.cand_o     = cand_q;
  assign bus.rsp_found  = found_q;
  assign bus.rsp_first  = first_q;
  assign bus.rsp_count  = count_q;
  assign bus.rsp_hitmap = hit_q;
endmodule
